// File: rtl/fft_pkg.sv
// Shared FFT datapath constants and helpers: default component width, ceil-log2,
// and lane slicing offsets for packed complex lane vectors.
package fft_pkg;

  localparam int unsigned FFT_BIT = 17;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // Bit offset of lane k inside a packed vector of bit_w-wide components.
  function automatic int unsigned lane_off(input int unsigned k, input int unsigned bit_w);
    return k * bit_w;
  endfunction

endpackage

// File: rtl/fft_rot_stage.sv
// One registered barrel stage: conditionally rotates all lanes left by SHIFT lanes
// (out k = in (k+SHIFT) mod LANES) and carries valid and the amount bits along.
module fft_rot_stage
  import fft_pkg::*;
#(
  parameter int unsigned BIT   = FFT_BIT,
  parameter int unsigned LANES = 4,
  parameter int unsigned SHIFT = 1,
  localparam int unsigned SEL_W = clog2(LANES)
) (
  input  logic                 iCLK,
  input  logic                 iRESET,
  input  logic                 iEN,
  input  logic                 iVALID,
  input  logic [SEL_W-1:0]     iAMT,
  input  logic [LANES*BIT-1:0] iRE,
  input  logic [LANES*BIT-1:0] iIM,
  output logic                 oVALID,
  output logic [SEL_W-1:0]     oAMT,
  output logic [LANES*BIT-1:0] oRE,
  output logic [LANES*BIT-1:0] oIM
);

  localparam int unsigned AMT_BIT = clog2(SHIFT);

  logic                 valid_q;
  logic [SEL_W-1:0]     amt_q;
  logic [LANES*BIT-1:0] re_q, re_d;
  logic [LANES*BIT-1:0] im_q, im_d;

  always_comb begin
    re_d = iRE;
    im_d = iIM;
    if (iAMT[AMT_BIT]) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        re_d[lane_off(k, BIT) +: BIT] = iRE[lane_off((k + SHIFT) % LANES, BIT) +: BIT];
        im_d[lane_off(k, BIT) +: BIT] = iIM[lane_off((k + SHIFT) % LANES, BIT) +: BIT];
      end
    end
  end

  // Data loads regardless of valid; it is don't-care whenever valid is low.
  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      valid_q <= 1'b0;
      amt_q   <= '0;
      re_q    <= '0;
      im_q    <= '0;
    end else if (iEN) begin
      valid_q <= iVALID;
      amt_q   <= iAMT;
      re_q    <= re_d;
      im_q    <= im_d;
    end
  end

  assign oVALID = valid_q;
  assign oAMT   = amt_q;
  assign oRE    = re_q;
  assign oIM    = im_q;

endmodule

// File: rtl/fft_lane_rotator.sv
// Pipelined complex lane rotator: left/right cyclic rotation by a per-beat amount with
// optional saturating conjugation, one registered barrel stage per amount bit.
module fft_lane_rotator
  import fft_pkg::*;
#(
  parameter int unsigned BIT   = FFT_BIT,
  parameter int unsigned LANES = 4,
  localparam int unsigned SEL_W = clog2(LANES)
) (
  input  logic                 iCLK,
  input  logic                 iRESET,
  input  logic                 iEN,
  input  logic                 iVALID,
  input  logic [SEL_W-1:0]     iSEL,
  input  logic                 iDIR,
  input  logic                 iCONJ,
  input  logic [LANES*BIT-1:0] iX_RE,
  input  logic [LANES*BIT-1:0] iX_IM,
  output logic                 oVALID,
  output logic [LANES*BIT-1:0] oY_RE,
  output logic [LANES*BIT-1:0] oY_IM
);

  localparam int unsigned W = LANES * BIT;
  localparam logic [BIT-1:0] MinVal = {1'b1, {(BIT-1){1'b0}}};
  localparam logic [BIT-1:0] MaxVal = {1'b0, {(BIT-1){1'b1}}};

  logic [SEL_W-1:0] sel_eff;
  logic [W-1:0]     im_conj;

  logic             valid_c [SEL_W+1];
  logic [SEL_W-1:0] amt_c   [SEL_W+1];
  logic [W-1:0]     re_c    [SEL_W+1];
  logic [W-1:0]     im_c    [SEL_W+1];

  // The most negative value has no positive counterpart, so clamp it.
  function automatic logic [BIT-1:0] neg_sat(input logic [BIT-1:0] v);
    if (v == MinVal) return MaxVal;
    return -v;
  endfunction

  // Right by sel == left by (LANES - sel) mod LANES; modular wrap is free in SEL_W bits.
  assign sel_eff = iDIR ? -iSEL : iSEL;

  always_comb begin
    im_conj = iX_IM;
    if (iCONJ) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        im_conj[lane_off(k, BIT) +: BIT] = neg_sat(iX_IM[lane_off(k, BIT) +: BIT]);
      end
    end
  end

  assign valid_c[0] = iVALID;
  assign amt_c[0]   = sel_eff;
  assign re_c[0]    = iX_RE;
  assign im_c[0]    = im_conj;

  for (genvar s = 0; s < SEL_W; s++) begin : g_stage
    fft_rot_stage #(
      .BIT  (BIT),
      .LANES(LANES),
      .SHIFT(1 << s)
    ) u_stage (
      .iCLK  (iCLK),
      .iRESET(iRESET),
      .iEN   (iEN),
      .iVALID(valid_c[s]),
      .iAMT  (amt_c[s]),
      .iRE   (re_c[s]),
      .iIM   (im_c[s]),
      .oVALID(valid_c[s+1]),
      .oAMT  (amt_c[s+1]),
      .oRE   (re_c[s+1]),
      .oIM   (im_c[s+1])
    );
  end

  assign oVALID = valid_c[SEL_W];
  assign oY_RE  = re_c[SEL_W];
  assign oY_IM  = im_c[SEL_W];

endmodule

// File: tb/tb_fft_lane_rotator.sv
// Self-checking bench for fft_lane_rotator: directed plan scenarios plus randomized traffic
// against a lane-index reference model and a latency delay line.
module tb_fft_lane_rotator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // 4-lane, 17-bit instance
  logic        rst_n, en, valid, dir, conj;
  logic [1:0]  sel;
  logic [67:0] xre, xim;
  logic        ovalid;
  logic [67:0] yre, yim;

  fft_lane_rotator #(.BIT(17), .LANES(4)) u_dut4 (
    .iCLK(clk), .iRESET(rst_n), .iEN(en), .iVALID(valid), .iSEL(sel), .iDIR(dir),
    .iCONJ(conj), .iX_RE(xre), .iX_IM(xim), .oVALID(ovalid), .oY_RE(yre), .oY_IM(yim)
  );

  // 8-lane, 12-bit instance
  logic        r8_n = 1'b0, en8 = 1'b1, v8 = 1'b0, dir8 = 1'b0, conj8 = 1'b0;
  logic [2:0]  sel8 = '0;
  logic [95:0] xre8 = '0, xim8 = '0;
  logic        ov8;
  logic [95:0] yre8, yim8;

  fft_lane_rotator #(.BIT(12), .LANES(8)) u_dut8 (
    .iCLK(clk), .iRESET(r8_n), .iEN(en8), .iVALID(v8), .iSEL(sel8), .iDIR(dir8),
    .iCONJ(conj8), .iX_RE(xre8), .iX_IM(xim8), .oVALID(ov8), .oY_RE(yre8), .oY_IM(yim8)
  );

  // 2-lane, 17-bit instance
  logic        r2_n = 1'b0, en2 = 1'b1, v2 = 1'b0, dir2 = 1'b0, conj2 = 1'b0;
  logic [0:0]  sel2 = '0;
  logic [33:0] xre2 = '0, xim2 = '0;
  logic        ov2;
  logic [33:0] yre2, yim2;

  fft_lane_rotator #(.BIT(17), .LANES(2)) u_dut2 (
    .iCLK(clk), .iRESET(r2_n), .iEN(en2), .iVALID(v2), .iSEL(sel2), .iDIR(dir2),
    .iCONJ(conj2), .iX_RE(xre2), .iX_IM(xim2), .oVALID(ov2), .oY_RE(yre2), .oY_IM(yim2)
  );

  // Reference model for the 4-lane instance: a 2-deep delay line of expected beats.
  logic        mv  [2];
  logic [67:0] mre [2];
  logic [67:0] mim [2];

  function automatic logic [67:0] pack4(input int a0, input int a1, input int a2, input int a3);
    int v[4];
    logic [67:0] r;
    v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
    for (int k = 0; k < 4; k++) r[k*17 +: 17] = v[k][16:0];
    return r;
  endfunction

  function automatic logic [67:0] rot4(input logic [67:0] x, input int s, input bit d);
    logic [67:0] r;
    for (int k = 0; k < 4; k++) begin
      int src;
      src = d ? (k - s + 4) % 4 : (k + s) % 4;
      r[k*17 +: 17] = x[src*17 +: 17];
    end
    return r;
  endfunction

  function automatic logic [67:0] conj4(input logic [67:0] x);
    logic [67:0] r;
    for (int k = 0; k < 4; k++) begin
      logic signed [16:0] t;
      int v;
      t = x[k*17 +: 17];
      v = t;
      v = (v == -65536) ? 65535 : -v;
      r[k*17 +: 17] = v[16:0];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin mv[i] = 1'b0; mre[i] = '0; mim[i] = '0; end
    end else if (en) begin
      mv[1] = mv[0]; mre[1] = mre[0]; mim[1] = mim[0];
      mv[0]  = valid;
      mre[0] = rot4(xre, int'(sel), dir);
      mim[0] = rot4(conj ? conj4(xim) : xim, int'(sel), dir);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; valid = 1'b0; sel = '0; dir = 1'b0; conj = 1'b0;
    xre = 68'({$urandom(), $urandom(), $urandom()});
    xim = 68'({$urandom(), $urandom(), $urandom()});
    repeat (2) begin
      tick();
      n_checks++;
      if (ovalid !== 1'b0 || yre !== '0 || yim !== '0)
        $display("FAIL reset_hold: got v=%b re=%h im=%h want v=0 re=0 im=0", ovalid, yre, yim);
      else n_pass++;
    end
    rst_n = 1'b1; valid = 1'b1; sel = 2'd1; dir = 1'b0;
    xre = pack4(10, 20, 30, 40); xim = pack4(1, 2, 3, 4);
    tick();
    valid = 1'b0; xre = 68'({$urandom(), $urandom(), $urandom()});
    n_checks++;
    if (ovalid !== 1'b0) $display("FAIL latency_early: got v=%b want v=0", ovalid);
    else n_pass++;
    tick();
    n_checks++;
    if (ovalid !== 1'b1 || yre !== pack4(20, 30, 40, 10) || yim !== pack4(2, 3, 4, 1))
      $display("FAIL latency_beat: got v=%b re=%h im=%h want v=1 re=%h im=%h",
               ovalid, yre, yim, pack4(20, 30, 40, 10), pack4(2, 3, 4, 1));
    else n_pass++;
    tick();
    n_checks++;
    if (ovalid !== 1'b0) $display("FAIL latency_after: got v=%b want v=0", ovalid);
    else n_pass++;
  endtask

  task automatic test_direction();
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 4; s++) begin
        valid = 1'b1; sel = 2'(s); dir = d[0]; conj = 1'b0;
        xre = pack4(0, 1, 2, 3);
        xim = 68'({$urandom(), $urandom(), $urandom()});
        tick();
        n_checks++;
        if (ovalid !== mv[1] || (mv[1] && (yre !== mre[1] || yim !== mim[1])))
          $display("FAIL direction d=%0d s=%0d: got v=%b re=%h im=%h want v=%b re=%h im=%h",
                   d, s, ovalid, yre, yim, mv[1], mre[1], mim[1]);
        else n_pass++;
      end
    end
    valid = 1'b0;
    repeat (2) begin
      tick();
      n_checks++;
      if (ovalid !== mv[1] || (mv[1] && (yre !== mre[1] || yim !== mim[1])))
        $display("FAIL direction_drain: got v=%b re=%h want v=%b re=%h", ovalid, yre, mv[1], mre[1]);
      else n_pass++;
    end
  endtask

  task automatic test_conj();
    logic [67:0] re_in;
    re_in = 68'({$urandom(), $urandom(), $urandom()});
    valid = 1'b1; conj = 1'b1; sel = '0; dir = 1'($urandom_range(1));
    xre = re_in; xim = pack4(-65536, 65535, 0, -5);
    tick();
    valid = 1'b0; conj = 1'b0;
    tick();
    n_checks++;
    if (ovalid !== 1'b1 || yim !== pack4(65535, -65535, 0, 5) || yre !== re_in)
      $display("FAIL conj_sat: got v=%b re=%h im=%h want v=1 re=%h im=%h",
               ovalid, yre, yim, re_in, pack4(65535, -65535, 0, 5));
    else n_pass++;
    tick();
  endtask

  task automatic test_stall();
    int en_seq[10]  = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
    int v_seq[10]   = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    int tag_seq[10] = '{1, 2, 99, 99, 99, 3, 4, 0, 0, 0};
    int order[$];
    for (int i = 0; i < 10; i++) begin
      bit en_at;
      en = en_seq[i][0]; valid = v_seq[i][0]; sel = '0; dir = 1'($urandom_range(1));
      conj = 1'($urandom_range(1));
      xre = 68'({$urandom(), $urandom(), $urandom()});
      xre[16:0] = tag_seq[i][16:0];
      xim = 68'({$urandom(), $urandom(), $urandom()});
      en_at = en;
      tick();
      n_checks++;
      if (ovalid !== mv[1] || (mv[1] && (yre !== mre[1] || yim !== mim[1])))
        $display("FAIL stall_cycle%0d: got v=%b re=%h want v=%b re=%h", i, ovalid, yre, mv[1], mre[1]);
      else n_pass++;
      if (en_at && ovalid === 1'b1) order.push_back(int'(yre[16:0]));
    end
    en = 1'b1;
    n_checks++;
    if (order.size() !== 4) $display("FAIL stall_count: got %0d beats want 4", order.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < order.size(); i++) begin
      n_checks++;
      if (order[i] !== i + 1) $display("FAIL stall_order[%0d]: got %0d want %0d", i, order[i], i + 1);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    // Reset during a stall must still clear.
    en = 1'b1; valid = 1'b1; sel = '0; xre = pack4(7, 7, 7, 7);
    tick();
    en = 1'b0; rst_n = 1'b0;
    tick();
    n_checks++;
    if (ovalid !== 1'b0 || yre !== '0) $display("FAIL reset_in_stall: got v=%b re=%h want v=0 re=0", ovalid, yre);
    else n_pass++;
    rst_n = 1'b1; en = 1'b1; valid = 1'b0;
    repeat (2) tick();
    // Beat 0x101 in flight; 0x102 presented while reset asserts; 0x103 as reset releases.
    valid = 1'b1; sel = 2'($urandom_range(3)); dir = 1'($urandom_range(1)); conj = 1'b0;
    xre = pack4(32'h101, 32'h101, 32'h101, 32'h101);
    tick();
    rst_n = 1'b0; xre = pack4(32'h102, 32'h102, 32'h102, 32'h102);
    tick();
    n_checks++;
    if (ovalid !== 1'b0 || yre !== '0 || yim !== '0)
      $display("FAIL reset_mid_clear: got v=%b re=%h im=%h want v=0 re=0 im=0", ovalid, yre, yim);
    else n_pass++;
    rst_n = 1'b1; xre = pack4(32'h103, 32'h103, 32'h103, 32'h103);
    tick();
    valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (ovalid !== mv[1] || (mv[1] && yre !== mre[1]) ||
          (ovalid === 1'b1 && (yre[16:0] === 17'h101 || yre[16:0] === 17'h102)))
        $display("FAIL reset_mid_after%0d: got v=%b re=%h want v=%b re=%h", i, ovalid, yre, mv[1], mre[1]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rst_n = ($urandom_range(39) != 0);
      en    = ($urandom_range(3) != 0);
      valid = 1'($urandom_range(1));
      sel   = 2'($urandom_range(3));
      dir   = 1'($urandom_range(1));
      conj  = 1'($urandom_range(1));
      xre   = 68'({$urandom(), $urandom(), $urandom()});
      xim   = 68'({$urandom(), $urandom(), $urandom()});
      if ($urandom_range(3) == 0) xim[($urandom_range(3))*17 +: 17] = 17'h10000;
      tick();
      n_checks++;
      if (ovalid !== mv[1] || (mv[1] && (yre !== mre[1] || yim !== mim[1])))
        $display("FAIL random%0d: got v=%b re=%h im=%h want v=%b re=%h im=%h",
                 i, ovalid, yre, yim, mv[1], mre[1], mim[1]);
      else n_pass++;
    end
    rst_n = 1'b1; en = 1'b1; valid = 1'b0;
  endtask

  task automatic test_generics();
    int exp8[8] = '{3, 4, 5, 6, 7, 0, 1, 2};
    logic [95:0] want8, ere8[12], eim8[12];
    r8_n = 1'b1; r2_n = 1'b1;
    v8 = 1'b1; sel8 = 3'd5; dir8 = 1'b1; conj8 = 1'b0;
    for (int k = 0; k < 8; k++) xre8[k*12 +: 12] = 12'(k);
    xim8 = 96'({$urandom(), $urandom(), $urandom()});
    for (int k = 0; k < 8; k++) want8[k*12 +: 12] = 12'(exp8[k]);
    for (int t = 1; t <= 3; t++) begin
      tick();
      v8 = 1'b0;
      n_checks++;
      if (ov8 !== (t == 3) || (t == 3 && yre8 !== want8))
        $display("FAIL lanes8_t%0d: got v=%b re=%h want v=%0d re=%h", t, ov8, yre8, t == 3, want8);
      else n_pass++;
    end
    tick();
    // Back-to-back random beats on the 8-lane instance, 3-cycle latency.
    for (int t = 1; t <= 14; t++) begin
      if (t <= 12) begin
        int s;
        bit d, c;
        s = $urandom_range(7); d = 1'($urandom_range(1)); c = 1'($urandom_range(1));
        v8 = 1'b1; sel8 = 3'(s); dir8 = d; conj8 = c;
        xre8 = 96'({$urandom(), $urandom(), $urandom()});
        xim8 = 96'({$urandom(), $urandom(), $urandom()});
        if ($urandom_range(2) == 0) xim8[11:0] = 12'h800;
        for (int k = 0; k < 8; k++) begin
          int src, v;
          logic signed [11:0] tv;
          src = d ? (k - s + 8) % 8 : (k + s) % 8;
          ere8[t-1][k*12 +: 12] = xre8[src*12 +: 12];
          tv = xim8[src*12 +: 12];
          v = tv;
          if (c) v = (v == -2048) ? 2047 : -v;
          eim8[t-1][k*12 +: 12] = v[11:0];
        end
      end else v8 = 1'b0;
      tick();
      n_checks++;
      if (t < 3) begin
        if (ov8 !== 1'b0) $display("FAIL lanes8_fill%0d: got v=%b want v=0", t, ov8);
        else n_pass++;
      end else if (ov8 !== 1'b1 || yre8 !== ere8[t-3] || yim8 !== eim8[t-3])
        $display("FAIL lanes8_beat%0d: got v=%b re=%h im=%h want v=1 re=%h im=%h",
                 t - 3, ov8, yre8, yim8, ere8[t-3], eim8[t-3]);
      else n_pass++;
    end
    // 2-lane instance: one-cycle latency, either direction by 1 swaps the lanes.
    for (int d = 0; d < 2; d++) begin
      v2 = 1'b1; sel2 = 1'b1; dir2 = d[0]; conj2 = 1'b0;
      xre2 = {17'd9, 17'd7}; xim2 = {17'd4, 17'd3};
      tick();
      v2 = 1'b0;
      n_checks++;
      if (ov2 !== 1'b1 || yre2 !== {17'd7, 17'd9} || yim2 !== {17'd3, 17'd4})
        $display("FAIL lanes2_d%0d: got v=%b re=%h im=%h want v=1 re=%h im=%h",
                 d, ov2, yre2, yim2, {17'd7, 17'd9}, {17'd3, 17'd4});
      else n_pass++;
      tick();
      n_checks++;
      if (ov2 !== 1'b0) $display("FAIL lanes2_after_d%0d: got v=%b want v=0", d, ov2);
      else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin mv[i] = 1'b0; mre[i] = '0; mim[i] = '0; end
    test_reset();
    test_direction();
    test_conj();
    test_stall();
    test_reset_mid();
    test_random();
    test_generics();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
